character_renderer: RTL
=======================

CHARACTER_RENDERER -- requirements
Module: character_renderer

Interface
REQ-001 SHALL provide parameters:
- FONT_WIDTH, default 5, glyph pixel width.
- FONT_HEIGHT, default 8, glyph pixel rows.
- CHAR_IMAGE_WIDTH, default 80, characters per text line.
- CHAR_IMAGE_HEIGHT, default 34, text lines per frame.
- FG_COLOR, default 24'hFFFFFF, lit-pixel colour.
- BG_COLOR, default 24'h000000, unlit-pixel colour.

REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- i_frame_start_stb  in  1  start rendering one frame.
- o_read_frame_stb  out  1  one-cycle pulse to the character buffer to rewind to frame start.
- o_char_req_en  out  1  character request level to the character buffer.
- i_char_rdy  in  1  character valid strobe from the character buffer.
- i_char  in  8  character code, valid while i_char_rdy=1.
- o_font_addr  out  8+clog2(FONT_HEIGHT)  font ROM address, equal to {char, glyph_row}.
- i_font_data  in  FONT_WIDTH  font ROM row, valid 1 cycle after o_font_addr; MSB is the leftmost pixel.
- o_axis_tdata  out  24  pixel colour.
- o_axis_tvalid  out  1  pixel valid.
- i_axis_tready  in  1  downstream ready.
- o_axis_tuser  out  1  start of frame; high on the first pixel only.
- o_axis_tlast  out  1  end of line; high on the last pixel of each pixel line.
- o_busy  out  1  high when the state is not IDLE.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-003 SHALL implement the states IDLE, START, REQ_CHAR, FONT_LOOKUP, FONT_LATCH and SHIFT_OUT.
REQ-004 IDLE: on i_frame_start_stb SHALL pulse o_read_frame_stb for one cycle, clear all counters and go to START; i_frame_start_stb SHALL be ignored in every other state.
REQ-005 START -> REQ_CHAR unconditionally on the next cycle.
REQ-006 REQ_CHAR: o_char_req_en SHALL be held at 1 until i_char_rdy=1 is sampled, then deasserted on the next edge. In the i_char_rdy cycle the block SHALL capture i_char and go to FONT_LOOKUP.
REQ-007 FONT_LOOKUP SHALL drive o_font_addr={captured char, glyph_row} and go to FONT_LATCH; FONT_LATCH SHALL register i_font_data into the shift register and go to SHIFT_OUT.
REQ-008 Captured char 8'h00 SHALL force the shift register to all zeros, regardless of i_font_data.
REQ-009 SHALL_OUT behaviour:
- o_axis_tvalid SHALL be 1.
- o_axis_tdata SHALL be FG_COLOR when the shift-register MSB is 1, else BG_COLOR.
- On each tvalid&tready the register SHALL shift left and the pixel column SHALL increment.
REQ-010 While tvalid=1 and tready=0, tdata, tuser and tlast SHALL hold stable.
REQ-011 After the last glyph column is accepted, counters SHALL advance as follows:
- If char column < CHAR_IMAGE_WIDTH-1: char column +1, go to REQ_CHAR.
- Else if glyph_row < FONT_HEIGHT-1: char column=0, glyph_row +1, go to REQ_CHAR.
- Else if char row < CHAR_IMAGE_HEIGHT-1: glyph_row=0, char row +1, go to REQ_CHAR.
- Else: pulse o_frame_done, go to IDLE.
REQ-012 Each character position SHALL be requested exactly FONT_HEIGHT times per frame, giving CHAR_IMAGE_WIDTH*CHAR_IMAGE_HEIGHT*FONT_HEIGHT requests per frame.
REQ-013 Default frame geometry SHALL be CHAR_IMAGE_WIDTH*FONT_WIDTH = 400 pixels per line and CHAR_IMAGE_HEIGHT*FONT_HEIGHT = 272 lines.
REQ-014 o_axis_tuser SHALL be 1 only for pixel (0,0); o_axis_tlast SHALL be 1 only for the final pixel of each line.
REQ-015 All counters SHALL be sized by clog2 of their limit and SHALL never wrap past their limits.

Reset
REQ-016 rst_n=0 sampled on any edge SHALL force IDLE and zero all counters, the shift register and o_font_addr.
REQ-017 During reset all outputs SHALL be 0, including o_axis_tvalid, o_char_req_en, o_read_frame_stb, o_busy and o_frame_done.
REQ-018 Reset mid-frame SHALL abandon the frame with no o_frame_done pulse; the next frame SHALL start cleanly from i_frame_start_stb.

Configuration
REQ-019 Macro CHAR_RENDERER_SPACING_EN, when defined, SHALL insert one BG_COLOR pixel after each glyph's last column.
REQ-020 With the macro defined, line width SHALL be CHAR_IMAGE_WIDTH*(FONT_WIDTH+1) = 480, and tlast SHALL fall on the spacing pixel.
REQ-021 With the macro undefined there SHALL be no spacing pixel, and line width SHALL be 400.

Verification
REQ-022 Reset release, tready=1, one i_frame_start_stb, model buffer returns 'A' -> exactly 400x272 = 108800 pixels, one tuser, 272 tlast, o_frame_done once, 21760 requests.
REQ-023 Font ROM row for 'A' = 5'b01110 -> first five pixels BG, FG, FG, FG, BG.
REQ-024 Char 8'h00 with ROM data 5'b11111 -> five BG_COLOR pixels.
REQ-025 tready toggled 0/1 every cycle -> tdata/tuser/tlast stable while stalled, pixel sequence identical to the tready=1 run.
REQ-026 rst_n=0 for 1 cycle at pixel 5000, then a new strobe -> no o_frame_done from the aborted frame; new frame starts with tuser at pixel (0,0).
REQ-027 CHAR_RENDERER_SPACING_EN defined -> 480 pixels per line, every 6th pixel BG_COLOR, tlast on pixel 479.

Source files
------------

// File: rtl/character_renderer.sv
// character_renderer: turns a stream of character codes into an AXI-Stream
// pixel stream. For each glyph row of each text line the block fetches every
// character of that line again, looks up the glyph row in an external font ROM,
// and shifts its pixels out MSB (leftmost) first.
// Optional feature macro: CHAR_RENDERER_SPACING_EN adds one background pixel
// after every glyph, so each character cell is FONT_WIDTH+1 pixels wide.
// FONT_HEIGHT must be at least 2 so the glyph-row field has at least one bit.
//
// Handshake: a pixel moves when o_axis_tvalid and i_axis_tready are both high
// on a rising edge; once tvalid is raised it, tdata, tuser and tlast hold until
// that transfer. On the character side, o_char_req_en stays high until the
// cycle in which i_char_rdy is sampled high, and i_char is taken in that cycle.
module character_renderer #(
  parameter int          FONT_WIDTH        = 5,
  parameter int          FONT_HEIGHT       = 8,
  parameter int          CHAR_IMAGE_WIDTH  = 80,
  parameter int          CHAR_IMAGE_HEIGHT = 34,
  parameter logic [23:0] FG_COLOR          = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR          = 24'h000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_frame_start_stb,
  output logic                              o_read_frame_stb,
  output logic                              o_char_req_en,
  input  logic                              i_char_rdy,
  input  logic [7:0]                        i_char,
  output logic [7+$clog2(FONT_HEIGHT):0]    o_font_addr,
  input  logic [FONT_WIDTH-1:0]             i_font_data,
  output logic [23:0]                       o_axis_tdata,
  output logic                              o_axis_tvalid,
  input  logic                              i_axis_tready,
  output logic                              o_axis_tuser,
  output logic                              o_axis_tlast,
  output logic                              o_busy,
  output logic                              o_frame_done
);

  localparam int ROW_W  = $clog2(FONT_HEIGHT);
  localparam int ADDR_W = 8 + ROW_W;
`ifdef CHAR_RENDERER_SPACING_EN
  // The spacing pixel is the extra column after the glyph.
  localparam int LAST_PIX = FONT_WIDTH;
`else
  localparam int LAST_PIX = FONT_WIDTH - 1;
`endif
  localparam int PIX_W  = (LAST_PIX > 0) ? $clog2(LAST_PIX + 1) : 1;
  localparam int CCOL_W = (CHAR_IMAGE_WIDTH > 1) ? $clog2(CHAR_IMAGE_WIDTH) : 1;
  localparam int CROW_W = (CHAR_IMAGE_HEIGHT > 1) ? $clog2(CHAR_IMAGE_HEIGHT) : 1;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LAST_PIX);
  localparam logic [CCOL_W-1:0] CCOL_LAST = CCOL_W'(CHAR_IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  GROW_LAST = ROW_W'(FONT_HEIGHT - 1);
  localparam logic [CROW_W-1:0] CROW_LAST = CROW_W'(CHAR_IMAGE_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_START       = 3'd1,
    S_REQ_CHAR    = 3'd2,
    S_FONT_LOOKUP = 3'd3,
    S_FONT_LATCH  = 3'd4,
    S_SHIFT_OUT   = 3'd5
  } state_t;

  state_t                state_q,     state_d;
  logic [PIX_W-1:0]      pix_col_q,   pix_col_d;
  logic [CCOL_W-1:0]     char_col_q,  char_col_d;
  logic [ROW_W-1:0]      glyph_row_q, glyph_row_d;
  logic [CROW_W-1:0]     char_row_q,  char_row_d;
  logic [7:0]            char_q,      char_d;
  logic [FONT_WIDTH-1:0] shift_q,     shift_d;
  logic [ADDR_W-1:0]     font_addr_q, font_addr_d;
  logic                  read_stb_q,  read_stb_d;
  logic                  req_en_q,    req_en_d;
  logic                  tvalid_q,    tvalid_d;
  logic                  done_q,      done_d;

  // Next-state and counter logic for the whole render sequence.
  always_comb begin
    state_d     = state_q;
    pix_col_d   = pix_col_q;
    char_col_d  = char_col_q;
    glyph_row_d = glyph_row_q;
    char_row_d  = char_row_q;
    char_d      = char_q;
    shift_d     = shift_q;
    font_addr_d = font_addr_q;
    read_stb_d  = 1'b0;
    req_en_d    = req_en_q;
    tvalid_d    = tvalid_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_frame_start_stb) begin
          read_stb_d  = 1'b1;
          pix_col_d   = '0;
          char_col_d  = '0;
          glyph_row_d = '0;
          char_row_d  = '0;
          state_d     = S_START;
        end
      end

      S_START: begin
        req_en_d = 1'b1;
        state_d  = S_REQ_CHAR;
      end

      S_REQ_CHAR: begin
        if (i_char_rdy) begin
          char_d      = i_char;
          req_en_d    = 1'b0;
          // Address goes out while in FONT_LOOKUP so the ROM row is ready in FONT_LATCH.
          font_addr_d = {i_char, glyph_row_q};
          state_d     = S_FONT_LOOKUP;
        end
      end

      S_FONT_LOOKUP: begin
        state_d = S_FONT_LATCH;
      end

      S_FONT_LATCH: begin
        // A NUL character always renders as background.
        shift_d   = (char_q == 8'h00) ? '0 : i_font_data;
        pix_col_d = '0;
        tvalid_d  = 1'b1;
        state_d   = S_SHIFT_OUT;
      end

      S_SHIFT_OUT: begin
        if (i_axis_tready) begin
          shift_d = shift_q << 1;
          if (pix_col_q != PIX_LAST) begin
            pix_col_d = pix_col_q + 1'b1;
          end else begin
            tvalid_d = 1'b0;
            if (char_col_q != CCOL_LAST) begin
              char_col_d = char_col_q + 1'b1;
              req_en_d   = 1'b1;
              state_d    = S_REQ_CHAR;
            end else if (glyph_row_q != GROW_LAST) begin
              char_col_d  = '0;
              glyph_row_d = glyph_row_q + 1'b1;
              req_en_d    = 1'b1;
              state_d     = S_REQ_CHAR;
            end else if (char_row_q != CROW_LAST) begin
              char_col_d  = '0;
              glyph_row_d = '0;
              char_row_d  = char_row_q + 1'b1;
              req_en_d    = 1'b1;
              state_d     = S_REQ_CHAR;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        req_en_d = 1'b0;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State, counters, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pix_col_q   <= '0;
      char_col_q  <= '0;
      glyph_row_q <= '0;
      char_row_q  <= '0;
      char_q      <= '0;
      shift_q     <= '0;
      font_addr_q <= '0;
      read_stb_q  <= 1'b0;
      req_en_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_col_q   <= pix_col_d;
      char_col_q  <= char_col_d;
      glyph_row_q <= glyph_row_d;
      char_row_q  <= char_row_d;
      char_q      <= char_d;
      shift_q     <= shift_d;
      font_addr_q <= font_addr_d;
      read_stb_q  <= read_stb_d;
      req_en_q    <= req_en_d;
      tvalid_q    <= tvalid_d;
      done_q      <= done_d;
    end
  end

  // Pixel outputs come straight from flops, so they hold while stalled.
  always_comb begin
    o_axis_tvalid = tvalid_q;
    o_axis_tdata  = '0;
    if (tvalid_q) o_axis_tdata = shift_q[FONT_WIDTH-1] ? FG_COLOR : BG_COLOR;
    o_axis_tuser  = tvalid_q && (pix_col_q == '0) && (char_col_q == '0) &&
                    (glyph_row_q == '0) && (char_row_q == '0);
    o_axis_tlast  = tvalid_q && (pix_col_q == PIX_LAST) && (char_col_q == CCOL_LAST);
    o_read_frame_stb = read_stb_q;
    o_char_req_en    = req_en_q;
    o_font_addr      = font_addr_q;
    o_busy           = (state_q != S_IDLE);
    o_frame_done     = done_q;
  end

endmodule
